// File: rtl/prog_sequencer.sv
// prog_sequencer: fetch/decode/execute controller for the 8-bit accumulator datapath.
// Instruction memory reads take one cycle; the datapath sees NOP (MOV A,A) outside EXEC.
module prog_sequencer #(
    parameter int PC_W  = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [PC_W:0]    prog_len,
    output logic [PC_W-1:0]  imem_addr,
    input  logic [7:0]       imem_data,
    output logic [7:0]       instr,
    output logic             exec_strobe,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             out_ready,
    output logic             out_valid,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] instr_count,
    output logic [2:0]       state_dbg
);

    localparam logic [7:0] NOP = 8'h80;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        FETCH    = 3'd1,
        DECODE   = 3'd2,
        WAIT_IN  = 3'd3,
        WAIT_OUT = 3'd4,
        EXEC     = 3'd5,
        HALT     = 3'd6
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [PC_W-1:0]   r_pc;
    logic [7:0]        r_ir;
    logic [CNT_W-1:0]  r_count;
    logic [PC_W:0]     w_len_m1;
    logic              w_last;

    // pc is zero-extended so a full-memory program (prog_len = 2^PC_W) ends at the top address
    assign w_len_m1 = prog_len - {{PC_W{1'b0}}, 1'b1};
    assign w_last   = ({1'b0, r_pc} == w_len_m1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc    <= '0;
            r_ir    <= NOP;
            r_count <= '0;
        end else begin
            case (r_state)
                IDLE, HALT: begin
                    if (start) begin
                        r_pc    <= '0;
                        r_count <= '0;
                    end
                end
                DECODE: r_ir <= imem_data;
                EXEC: begin
                    r_count <= r_count + CNT_W'(1);
                    if (!w_last) begin
                        r_pc <= r_pc + PC_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs decode only registered state and ir, never the handshake inputs
    always_comb begin
        w_next      = r_state;
        instr       = NOP;
        exec_strobe = 1'b0;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        case (r_state)
            IDLE, HALT: begin
                if (start) begin
                    w_next = (prog_len == '0) ? HALT : FETCH;
                end
            end
            FETCH: w_next = DECODE;
            DECODE: begin
                case (imem_data[7:6])
                    2'b00:   w_next = WAIT_IN;
                    2'b11:   w_next = WAIT_OUT;
                    default: w_next = EXEC;
                endcase
            end
            WAIT_IN: begin
                if (in_valid) begin
                    w_next = EXEC;
                end
            end
            WAIT_OUT: begin
                if (out_ready) begin
                    w_next = EXEC;
                end
            end
            EXEC: begin
                instr       = r_ir;
                exec_strobe = 1'b1;
                in_ready    = (r_ir[7:6] == 2'b00);
                out_valid   = (r_ir[7:6] == 2'b11);
                w_next      = w_last ? HALT : FETCH;
            end
            default: w_next = IDLE;
        endcase
    end

    assign imem_addr   = r_pc;
    assign instr_count = r_count;
    assign state_dbg   = r_state;
    assign busy        = (r_state != IDLE) && (r_state != HALT);
    assign done        = (r_state == HALT);

endmodule

// File: tb/tb_prog_sequencer.sv
// tb_prog_sequencer: table-driven program runs with an expected-instruction scoreboard
// and a small accumulator datapath model driven by the sequencer's instr stream.
module tb_prog_sequencer;

    typedef struct {
        logic [4:0] progLen;
        int         inStall;
        int         outStall;
        int         restartAt;
        int         expBusy;
        int         expWaitIn;
        int         expCount;
        logic [3:0] expPc;
        int         expOutPulses;
        logic [7:0] expOut;
    } VecRow;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [4:0]  prog_len = '0;
    logic [3:0]  imem_addr;
    logic [7:0]  imem_data;
    logic [7:0]  instr;
    logic        exec_strobe;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        out_ready = 1'b0;
    logic        out_valid;
    logic        busy;
    logic        done;
    logic [15:0] instr_count;
    logic [2:0]  state_dbg;

    logic [7:0]  mem [16];
    logic [7:0]  expQ [$];
    logic [7:0]  regs [8];
    logic [7:0]  lastOut;
    int          outPulses;
    int          checks = 0;
    int          errors = 0;
    int          inStall = 0;
    int          outStall = 0;
    int          inWait = 0;
    int          outWait = 0;
    VecRow       vecs [9];

    prog_sequencer #(.PC_W(4), .CNT_W(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .prog_len    (prog_len),
        .imem_addr   (imem_addr),
        .imem_data   (imem_data),
        .instr       (instr),
        .exec_strobe (exec_strobe),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .out_ready   (out_ready),
        .out_valid   (out_valid),
        .busy        (busy),
        .done        (done),
        .instr_count (instr_count),
        .state_dbg   (state_dbg)
    );

    always #5 clk = ~clk;

    always @(posedge clk) imem_data <= mem[imem_addr];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Handshake sources hold off for the requested number of wait cycles and are high elsewhere
    always @(negedge clk) begin
        if (state_dbg == 3'd3) begin
            in_valid = (inWait >= inStall);
            inWait++;
        end else begin
            in_valid = 1'b1;
            inWait = 0;
        end
        if (state_dbg == 3'd4) begin
            out_ready = (outWait >= outStall);
            outWait++;
        end else begin
            out_ready = 1'b1;
            outWait = 0;
        end
    end

    always @(negedge clk) begin
        logic [7:0] expWord;
        if (!rst) begin
            if (exec_strobe) begin
                if (expQ.size() == 0) begin
                    checkOutput("exec without pending instr", {31'd0, exec_strobe}, 32'd0);
                end else begin
                    expWord = expQ.pop_front();
                    checkOutput("exec instr", {24'd0, instr}, {24'd0, expWord});
                    checkOutput("exec in_ready", {31'd0, in_ready}, {31'd0, expWord[7:6] == 2'b00});
                    checkOutput("exec out_valid", {31'd0, out_valid}, {31'd0, expWord[7:6] == 2'b11});
                end
                case (instr[7:6])
                    2'b00: regs[instr[5:3]] = 8'h05;
                    2'b01: regs[0] = regs[0] + regs[instr[2:0]];
                    2'b10: regs[instr[5:3]] = regs[instr[2:0]];
                    default: ;
                endcase
                if (out_valid) begin
                    outPulses++;
                    lastOut = regs[instr[2:0]];
                end
            end else begin
                checkOutput("non-exec instr nop", {24'd0, instr}, 32'h80);
                checkOutput("non-exec handshakes", {30'd0, in_ready, out_valid}, 32'd0);
            end
        end
    end

    task automatic launch(input logic [4:0] len);
        for (int i = 0; i < 8; i++) regs[i] = 8'h00;
        outPulses = 0;
        lastOut = 8'h00;
        for (int i = 0; i < int'(len); i++) expQ.push_back(mem[i]);
        prog_len = len;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic applyStimulus(input VecRow v);
        int busyCycles;
        int waitInCycles;
        int edges;
        checkOutput("queue empty before run", expQ.size(), 0);
        expQ.delete();
        inStall = v.inStall;
        outStall = v.outStall;
        launch(v.progLen);
        edges = 1;
        checkOutput("state after start", {29'd0, state_dbg}, (v.progLen == 0) ? 32'd6 : 32'd1);
        checkOutput("count cleared on start", {16'd0, instr_count}, 32'd0);
        checkOutput("addr zero on start", {28'd0, imem_addr}, 32'd0);
        busyCycles = 0;
        waitInCycles = 0;
        while (!done && edges < 400) begin
            if (busy) busyCycles++;
            if (state_dbg == 3'd3) waitInCycles++;
            if (busyCycles == v.restartAt) start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            edges++;
        end
        checkOutput("done reached", {31'd0, done}, 32'd1);
        checkOutput("edges to done", edges, v.expBusy + 1);
        checkOutput("busy cycles", busyCycles, v.expBusy);
        checkOutput("wait_in cycles", waitInCycles, v.expWaitIn);
        checkOutput("instr_count", {16'd0, instr_count}, v.expCount);
        checkOutput("final pc", {28'd0, imem_addr}, {28'd0, v.expPc});
        checkOutput("halt state", {29'd0, state_dbg, busy}, 32'hC);
        checkOutput("queue drained", expQ.size(), 0);
        checkOutput("out pulses", outPulses, v.expOutPulses);
        checkOutput("datapath out", {24'd0, lastOut}, {24'd0, v.expOut});
        repeat (3) begin @(posedge clk); #1; end
        checkOutput("count held in halt", {16'd0, instr_count}, v.expCount);
        checkOutput("pc held in halt", {28'd0, imem_addr}, {28'd0, v.expPc});
    endtask

    task automatic resetDuring(input logic [2:0] st);
        int n;
        expQ.delete();
        inStall = (st == 3'd3) ? 1000 : 0;
        outStall = (st == 3'd4) ? 1000 : 0;
        launch(5'd4);
        n = 0;
        while (state_dbg != st && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput("reached wait state", {29'd0, state_dbg}, {29'd0, st});
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        checkOutput("reset state", {29'd0, state_dbg}, 32'd0);
        checkOutput("reset instr", {24'd0, instr}, 32'h80);
        checkOutput("reset strobes", {29'd0, exec_strobe, in_ready, out_valid}, 32'd0);
        checkOutput("reset count", {16'd0, instr_count}, 32'd0);
        checkOutput("reset pc", {28'd0, imem_addr}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        expQ.delete();
        inStall = 0;
        outStall = 0;
        repeat (10) begin @(posedge clk); #1; end
        checkOutput("idle after reset", {29'd0, state_dbg}, 32'd0);
        checkOutput("not busy after reset", {30'd0, busy, done}, 32'd0);
    endtask

    initial begin
        mem[0] = 8'h08;
        mem[1] = 8'h81;
        mem[2] = 8'h41;
        mem[3] = 8'hC0;
        for (int i = 4; i < 16; i++) mem[i] = (i % 2 == 0) ? 8'h41 : 8'h88;

        // progLen inStall outStall restartAt expBusy expWaitIn expCount expPc expOutPulses expOut
        vecs[0] = '{5'd4,  0, 0, -1, 14, 1, 4,  4'd3,  1, 8'h0A};
        vecs[1] = '{5'd4,  5, 0, -1, 19, 6, 4,  4'd3,  1, 8'h0A};
        vecs[2] = '{5'd4,  0, 3, -1, 17, 1, 4,  4'd3,  1, 8'h0A};
        vecs[3] = '{5'd0,  0, 0, -1,  0, 0, 0,  4'd0,  0, 8'h00};
        vecs[4] = '{5'd16, 0, 0, -1, 50, 1, 16, 4'd15, 1, 8'h0A};
        vecs[5] = '{5'd4,  0, 0,  5, 14, 1, 4,  4'd3,  1, 8'h0A};
        vecs[6] = '{5'd1,  0, 0, -1,  4, 1, 1,  4'd0,  0, 8'h00};
        vecs[7] = '{5'd2,  2, 0, -1,  9, 3, 2,  4'd1,  0, 8'h00};
        vecs[8] = '{5'd4,  2, 1, -1, 17, 3, 4,  4'd3,  1, 8'h0A};

        repeat (3) @(posedge clk);
        #1;
        checkOutput("por state", {29'd0, state_dbg}, 32'd0);
        checkOutput("por instr", {24'd0, instr}, 32'h80);
        checkOutput("por outputs", {27'd0, exec_strobe, in_ready, out_valid, busy, done}, 32'd0);
        checkOutput("por count", {16'd0, instr_count}, 32'd0);
        checkOutput("por pc", {28'd0, imem_addr}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int r = 0; r < 9; r++) begin
            $display("[TB] vector %0d prog_len=%0d", r, vecs[r].progLen);
            applyStimulus(vecs[r]);
        end

        $display("[TB] reset during WAIT_IN");
        resetDuring(3'd3);
        $display("[TB] reset during WAIT_OUT");
        resetDuring(3'd4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
